// File: rtl/uart_rx_fsm_if.sv
// Handshake bundle between the UART RX frame sequencer and its datapath blocks.
// master = sequencer side, slave = sampler/deserializer/checker side.
interface uart_rx_fsm_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 16
) ();
  localparam int EW = $clog2(N);
  localparam int BW = $clog2(DATA_WIDTH + 4);

  logic          RX_IN;
  logic          sample_valid;
  logic          strt_glitch;
  logic          par_err;
  logic          stp_err;
  logic [EW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          dat_samp_en;
  logic          strt_chk_en;
  logic          deser_en;
  logic          par_chk_en;
  logic          stp_chk_en;
  logic          DATA_VALID;
  logic          parity_error;
  logic          stop_error;

  modport master (
    input  RX_IN, sample_valid, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
           par_chk_en, stp_chk_en, DATA_VALID, parity_error, stop_error
  );

  modport slave (
    output RX_IN, sample_valid, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
           par_chk_en, stp_chk_en, DATA_VALID, parity_error, stop_error
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: start detection, edge/bit counters, per-phase
// enables, registered parity/stop error flags and a DATA_VALID pulse.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 16,
  parameter int PAR_EN     = 0
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fsm_if.master rx_if
);
  localparam int EW = $clog2(N);
  localparam int BW = $clog2(DATA_WIDTH + 4);
  localparam logic [EW-1:0] EDGE_LAST = EW'(N - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_e;

  state_e        state_q, state_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          parity_error_q, parity_error_d;
  logic          stop_error_q, stop_error_d;
  logic          dat_samp_en_q, dat_samp_en_d;
  logic          strt_chk_en_q, strt_chk_en_d;
  logic          deser_en_q, deser_en_d;
  logic          par_chk_en_q, par_chk_en_d;
  logic          stp_chk_en_q, stp_chk_en_d;
  logic          data_valid_q, data_valid_d;
  logic          edge_last;

  always_comb begin
    state_d        = state_q;
    edge_cnt_d     = edge_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    parity_error_d = parity_error_q;
    stop_error_d   = stop_error_q;
    edge_last      = (edge_cnt_q == EDGE_LAST);

    if (state_q inside {START, DATA, PARITY, STOP}) begin
      if (edge_last) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BW'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + EW'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_if.RX_IN) begin
          state_d        = START;
          parity_error_d = 1'b0;
          stop_error_d   = 1'b0;
        end
      end
      START: begin
        if (rx_if.sample_valid && rx_if.strt_glitch) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
          bit_cnt_d  = '0;
        end else if (edge_last) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (edge_last && bit_cnt_q == BIT_LAST)
          state_d = (PAR_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        if (rx_if.sample_valid) parity_error_d = rx_if.par_err;
        if (edge_last) state_d = STOP;
      end
      STOP: begin
        // A sample ends the frame early; reaching the last edge without one is a timeout.
        if (rx_if.sample_valid || edge_last) begin
          state_d      = DONE;
          stop_error_d = rx_if.sample_valid ? rx_if.stp_err : 1'b1;
          edge_cnt_d   = '0;
          bit_cnt_d    = '0;
        end
      end
      DONE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_if.RX_IN) begin
          state_d        = START;
          parity_error_d = 1'b0;
          stop_error_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies track state_q.
    dat_samp_en_d = state_d inside {START, DATA, PARITY, STOP};
    strt_chk_en_d = (state_d == START);
    deser_en_d    = (state_d == DATA);
    par_chk_en_d  = (state_d == PARITY);
    stp_chk_en_d  = (state_d == STOP);
    data_valid_d  = (state_d == DONE) && !parity_error_d && !stop_error_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      dat_samp_en_q  <= 1'b0;
      strt_chk_en_q  <= 1'b0;
      deser_en_q     <= 1'b0;
      par_chk_en_q   <= 1'b0;
      stp_chk_en_q   <= 1'b0;
      data_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
      dat_samp_en_q  <= dat_samp_en_d;
      strt_chk_en_q  <= strt_chk_en_d;
      deser_en_q     <= deser_en_d;
      par_chk_en_q   <= par_chk_en_d;
      stp_chk_en_q   <= stp_chk_en_d;
      data_valid_q   <= data_valid_d;
    end
  end

  assign rx_if.edge_cnt     = edge_cnt_q;
  assign rx_if.bit_cnt      = bit_cnt_q;
  assign rx_if.dat_samp_en  = dat_samp_en_q;
  assign rx_if.strt_chk_en  = strt_chk_en_q;
  assign rx_if.deser_en     = deser_en_q;
  assign rx_if.par_chk_en   = par_chk_en_q;
  assign rx_if.stp_chk_en   = stp_chk_en_q;
  assign rx_if.DATA_VALID   = data_valid_q;
  assign rx_if.parity_error = parity_error_q;
  assign rx_if.stop_error   = stop_error_q;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: one instance without parity, one with, each checked
// cycle-by-cycle against a frame-timeline model built from bit/edge arithmetic.
module tb_uart_rx_fsm;
  localparam int N_P = 16;
  localparam int DW  = 8;
  localparam int NEVER = 1 << 30;

  typedef struct packed {
    logic [3:0] ec;
    logic [3:0] bc;
    logic samp, strt, deser, par, stp, dv, perr, serr;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic rx_in [2];
  logic sv [2];
  logic sg [2];
  logic pe [2];
  logic se [2];
  obs_t obs [2];
  int   n_vec;
  int   n_err;

  always #5 clk = ~clk;

  uart_rx_fsm_if #(.DATA_WIDTH(DW), .N(N_P)) if0 ();
  uart_rx_fsm_if #(.DATA_WIDTH(DW), .N(N_P)) if1 ();

  assign if0.RX_IN = rx_in[0];  assign if1.RX_IN = rx_in[1];
  assign if0.sample_valid = sv[0];  assign if1.sample_valid = sv[1];
  assign if0.strt_glitch = sg[0];  assign if1.strt_glitch = sg[1];
  assign if0.par_err = pe[0];  assign if1.par_err = pe[1];
  assign if0.stp_err = se[0];  assign if1.stp_err = se[1];

  assign obs[0] = {if0.edge_cnt, if0.bit_cnt, if0.dat_samp_en, if0.strt_chk_en, if0.deser_en,
                   if0.par_chk_en, if0.stp_chk_en, if0.DATA_VALID, if0.parity_error, if0.stop_error};
  assign obs[1] = {if1.edge_cnt, if1.bit_cnt, if1.dat_samp_en, if1.strt_chk_en, if1.deser_en,
                   if1.par_chk_en, if1.stp_chk_en, if1.DATA_VALID, if1.parity_error, if1.stop_error};

  uart_rx_fsm #(.DATA_WIDTH(DW), .N(N_P), .PAR_EN(0)) dut0 (.clk(clk), .rst(rst), .rx_if(if0));
  uart_rx_fsm #(.DATA_WIDTH(DW), .N(N_P), .PAR_EN(1)) dut1 (.clk(clk), .rst(rst), .rx_if(if1));

  // Expected outputs at cycle t of a frame (t = 0 is the first START cycle).
  function automatic obs_t model(input int pen, input int t, input int done_t, input int abort_t,
                                 input bit b2b, input bit pf, input bit sf, input int e_par);
    obs_t m;
    int   b;
    m = '0;
    b = t / N_P;
    if (t >= abort_t) return m;
    if (t > done_t) begin
      if (b2b) begin m.samp = 1'b1; m.strt = 1'b1; end
      else begin m.perr = pf; m.serr = sf; end
      return m;
    end
    if (t == done_t) begin
      m.perr = pf; m.serr = sf; m.dv = !pf && !sf;
      return m;
    end
    m.ec = 4'(t % N_P);
    m.bc = 4'(b);
    m.samp = 1'b1;
    if (b == 0) m.strt = 1'b1;
    else if (b <= DW) m.deser = 1'b1;
    else if (pen != 0 && b == DW + 1) m.par = 1'b1;
    else m.stp = 1'b1;
    if (pen != 0 && t > (1 + DW) * N_P + e_par) m.perr = pf;
    return m;
  endfunction

  task automatic drive_frame(input int p, input bit started, input bit glitch, input bit perr,
                             input bit serr, input bit timeout, input int es, input bit b2b,
                             output int deser_cycles, output int dv_cycles);
    int   e_par, stop_t, done_t, abort_t, last;
    bit   pf, sf;
    obs_t exp_o, got;
    e_par   = $urandom_range(1, 14);
    stop_t  = (1 + DW + p) * N_P;
    done_t  = timeout ? stop_t + N_P : stop_t + es + 1;
    abort_t = glitch ? 10 : NEVER;
    last    = glitch ? abort_t : done_t + 1;
    pf      = (p != 0) && perr;
    sf      = timeout ? 1'b1 : serr;
    deser_cycles = 0;
    dv_cycles    = 0;
    if (!started) begin
      rx_in[p] = 1'b0; sv[p] = 1'b0;
      @(posedge clk); #1;
    end
    for (int t = 0; t <= last; t++) begin
      int b, e;
      exp_o = model(p, t, done_t, abort_t, b2b && !glitch, pf, sf, e_par);
      got = obs[p];
      if (t == done_t) begin got.ec = '0; got.bc = '0; end
      n_vec++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL frame inst=%0d t=%0d got=%b required=%b", p, t, got, exp_o);
      end
      if (got.deser) deser_cycles++;
      if (got.dv) dv_cycles++;
      if (t == last) break;
      b = t / N_P;
      e = t % N_P;
      rx_in[p] = 1'($urandom); sv[p] = 1'($urandom); sg[p] = 1'($urandom);
      pe[p] = 1'($urandom); se[p] = 1'($urandom);
      if (t == done_t) begin
        rx_in[p] = !b2b;
      end else if (b == 0) begin
        sv[p] = (e == 9);
        if (e == 9) sg[p] = glitch;
        if (glitch) rx_in[p] = (t >= 2);
      end else if (b <= DW) begin
        if (glitch) rx_in[p] = 1'b1;
      end else if (p != 0 && b == DW + 1) begin
        sv[p] = (e == e_par);
        if (e == e_par) pe[p] = perr;
      end else begin
        sv[p] = !timeout && (e == es);
        if (sv[p]) se[p] = serr;
      end
      @(posedge clk); #1;
    end
    if (!(b2b && !glitch)) begin rx_in[p] = 1'b1; sv[p] = 1'b0; end
  endtask

  task automatic test_reset();
    int d, v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if (obs[p] !== obs_t'(0)) begin
        n_err++; $display("FAIL reset inst=%0d got=%h required=0", p, obs[p]);
      end
    end
    rx_in[0] = 1'b0;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    drive_frame(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0, d, v);
  endtask

  task automatic test_clean();
    int d, v;
    drive_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0, d, v);
    n_vec++;
    if (d !== 128) begin n_err++; $display("FAIL clean_deser_cycles got=%0d required=128", d); end
    n_vec++;
    if (v !== 1) begin n_err++; $display("FAIL clean_dv_pulses got=%0d required=1", v); end
    drive_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0, d, v);
    n_vec++;
    if (v !== 1) begin n_err++; $display("FAIL clean_par_dv_pulses got=%0d required=1", v); end
  endtask

  task automatic test_glitch();
    int d, v;
    drive_frame(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9, 1'b0, d, v);
    n_vec++;
    if (v !== 0) begin n_err++; $display("FAIL glitch_dv got=%0d required=0", v); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (obs[0] !== obs_t'(0)) begin n_err++; $display("FAIL glitch_idle got=%h required=0", obs[0]); end
  endtask

  task automatic test_parity_error();
    int d, v;
    drive_frame(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9, 1'b0, d, v);
    n_vec++;
    if (v !== 0) begin n_err++; $display("FAIL parity_err_dv got=%0d required=0", v); end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (obs[1].perr !== 1'b1) begin
      n_err++; $display("FAIL parity_flag_hold got=%b required=1", obs[1].perr);
    end
    drive_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0, d, v);
  endtask

  task automatic test_stop_timeout();
    int d, v;
    drive_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0, d, v);
    n_vec++;
    if (v !== 0) begin n_err++; $display("FAIL timeout_dv got=%0d required=0", v); end
    drive_frame(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5, 1'b0, d, v);
  endtask

  task automatic test_back_to_back();
    int d, v;
    drive_frame(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9, 1'b1, d, v);
    drive_frame(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0, d, v);
    n_vec++;
    if (v !== 1) begin n_err++; $display("FAIL b2b_second_dv got=%0d required=1", v); end
  endtask

  task automatic test_reset_mid_data();
    int d, v;
    obs_t exp_o;
    rx_in[0] = 1'b0; sv[0] = 1'b0;
    @(posedge clk); #1;
    for (int t = 0; t < 40; t++) begin
      rx_in[0] = 1'($urandom); sg[0] = 1'($urandom);
      @(posedge clk); #1;
    end
    exp_o = model(0, 40, NEVER, NEVER, 1'b0, 1'b0, 1'b0, 0);
    n_vec++;
    if (obs[0] !== exp_o) begin n_err++; $display("FAIL pre_reset got=%h required=%h", obs[0], exp_o); end
    rx_in[0] = 1'b1;
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if (obs[0] !== obs_t'(0)) begin n_err++; $display("FAIL async_reset got=%h required=0", obs[0]); end
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (obs[0] !== obs_t'(0)) begin n_err++; $display("FAIL post_reset_idle got=%h required=0", obs[0]); end
    drive_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0, d, v);
  endtask

  task automatic test_random();
    int d, v;
    bit started, glitch, b2b;
    started = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int p;
      p = (i < 4) ? 0 : 1;
      if (i == 4) started = 1'b0;
      glitch = !started && ($urandom_range(0, 5) == 0);
      b2b = !glitch && (i != 3) && (i != 7) && 1'($urandom);
      drive_frame(p, started, glitch, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15), b2b, d, v);
      started = b2b;
      if (!b2b) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int p = 0; p < 2; p++) begin
      rx_in[p] = 1'b1; sv[p] = 1'b0; sg[p] = 1'b0; pe[p] = 1'b0; se[p] = 1'b0;
    end
    test_reset();
    test_clean();
    test_glitch();
    test_parity_error();
    test_stop_timeout();
    test_back_to_back();
    test_reset_mid_data();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Frame-sequencing controller for the UART receiver. Detects the start edge on `RX_IN` and owns the oversampling edge counter and the frame bit counter. It enables the data sampler, deserializer, and start/parity/stop checkers in turn, then registers the per-frame error flags and pulses `DATA_VALID` when a clean frame completes. It sits between the serial input and the RX datapath blocks, and those blocks are its only consumers.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `N`, 16: oversampling ratio, in clk cycles per bit; even, ≥8.
- `PAR_EN`, 0: 1 = frame carries a parity bit between the data and stop bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `RX_IN`  in  1  serial line, idle high; already synchronised upstream.
- `sample_valid`  in  1  one-cycle strobe from the sampler: mid-bit majority sample is ready.
- `strt_glitch`  in  1  start checker result; qualified by `sample_valid` in START.
- `par_err`  in  1  parity checker result; qualified by `sample_valid` in PARITY.
- `stp_err`  in  1  stop checker result; qualified by `sample_valid` in STOP.
- `edge_cnt`  out  $clog2(N)  cycle position within the current bit.
- `bit_cnt`  out  $clog2(DATA_WIDTH+4)  bit index within the frame; start bit = 0.
- `dat_samp_en`  out  1  sampler enable.
- `strt_chk_en`, `deser_en`, `par_chk_en`, `stp_chk_en`  out  1 each  per-phase enables.
- `DATA_VALID`  out  1  one-cycle pulse: frame received without error.
- `parity_error`, `stop_error`  out  1  registered frame error flags.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE. State, counters and flags are registered.
- IDLE: counters held at 0. `RX_IN`==0 → START, `edge_cnt`=0, `bit_cnt`=0, and both error flags clear on this transition.
- Counting, in START/DATA/PARITY/STOP:
  - `edge_cnt` increments every cycle.
  - At N-1, `edge_cnt` wraps to 0 and `bit_cnt` increments.
- START:
  - `strt_chk_en`=1.
  - `sample_valid`&&`strt_glitch` → IDLE next cycle. Counters clear, no flags set, no `DATA_VALID`.
  - Otherwise, at `edge_cnt`==N-1 → DATA.
- DATA:
  - `deser_en`=1.
  - At `edge_cnt`==N-1 with `bit_cnt`==DATA_WIDTH → PARITY if PAR_EN, else STOP.
- PARITY:
  - `par_chk_en`=1.
  - On `sample_valid`, `parity_error` <= `par_err`.
  - At `edge_cnt`==N-1 → STOP.
- STOP:
  - `stp_chk_en`=1.
  - On `sample_valid`, `stop_error` <= `stp_err` → DONE next cycle. DONE does not wait for the end of the stop bit.
  - Timeout: if `edge_cnt` reaches N-1 without `sample_valid` → DONE with `stop_error`=1.
- DONE, exactly one cycle:
  - `DATA_VALID` = !`parity_error` && !`stop_error`.
  - Next state is START if `RX_IN`==0 (back-to-back frame; counters zeroed, flags cleared), else IDLE.
- Enables are decoded from state:
  - `dat_samp_en` = 1 in START/DATA/PARITY/STOP.
  - All enables are 0 in IDLE and DONE.
- Ignored inputs:
  - `RX_IN` is ignored outside IDLE and DONE.
  - `sample_valid` is ignored in IDLE and DONE.
  - Checker inputs are ignored outside their own phase.
- Error flags hold their value from DONE until the next START entry.

## Timing
- Reset: asynchronous.
  - State goes to IDLE immediately.
  - All outputs, including counters and flags, go to 0 immediately, including mid-frame.
  - First start detection is possible on the first clk edge after `rst` deasserts.
- T0 = first cycle in START.
  - START occupies T0..T0+N-1.
  - DATA bit k (k = 1..DATA_WIDTH) occupies T0+k·N..T0+k·N+N-1, with `bit_cnt`=k.
  - PARITY, if present, occupies the next N cycles.
- Stop bit begins at S = T0+(1+DATA_WIDTH+PAR_EN)·N.
  - With `sample_valid` at `edge_cnt`==e, DONE/`DATA_VALID` occurs at S+e+1.
  - With the default sampler at e = N/2+1, N=16, DATA_WIDTH=8, PAR_EN=0: `DATA_VALID` at T0+154.
- Start detection latency: `RX_IN` low sampled at edge t → START from t+1.
- Glitch abort latency: `sample_valid`&&`strt_glitch` at cycle c → IDLE at c+1.
- DONE→START back-to-back gives no idle cycle; the new T0 = DONE+1.

## Test plan
- Clean frame (N=16, DW=8, PAR_EN=0; bench drives `sample_valid` at `edge_cnt`==9, all checker flags 0):
  - `DATA_VALID` pulses once at T0+154.
  - Both error flags stay 0.
  - `deser_en` is high for exactly 128 cycles.
  - `bit_cnt` reaches 9 in STOP.
- Start glitch (`RX_IN` low for 3 cycles, `strt_glitch`=1 at the START sample):
  - State returns to IDLE the next cycle.
  - Counters are 0; no `DATA_VALID`; flags unchanged.
- Parity error (PAR_EN=1, `par_err`=1 at the PARITY sample):
  - `parity_error`=1 and `DATA_VALID` stays 0.
  - DONE occurs at T0+170.
  - Flags clear on the next START.
- Stop timeout (`sample_valid` suppressed in STOP):
  - DONE occurs the cycle after `edge_cnt`==15 in STOP.
  - `stop_error`=1, no `DATA_VALID`.
- Back-to-back (`RX_IN`=0 during the DONE cycle):
  - START is entered the next cycle with `edge_cnt`=0 and both flags 0.
  - The second frame produces `DATA_VALID` at its own T0+154.
- Reset mid-DATA (`rst` asserted between clk edges):
  - All outputs go to 0 before the next edge.
  - State is IDLE after deassertion.
  - The next `RX_IN` low starts a fresh frame.
